// File: rtl/branch_predict_tournament_pkg.sv
// Shared types and constant helpers for the tournament branch predictor.
package bp_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Pattern tables start weakly taken.
    function automatic int unsigned pht_init_val(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 1);
    endfunction

    // Chooser starts weakly favouring the local predictor.
    function automatic int unsigned chooser_init_val(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predict_tournament_sat_counter.sv
// Combinational next value of a saturating up/down counter.
module sat_counter_update #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] cnt,
    input  logic                inc,
    input  logic                dec,
    output logic [CTR_BITS-1:0] nxt
);

    // Step by one toward the requested direction, holding at either bound.
    always_comb begin
        nxt = cnt;
        if (inc && !dec) begin
            if (cnt != '1) nxt = cnt + CTR_BITS'(1);
        end else if (dec && !inc) begin
            if (cnt != '0) nxt = cnt - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/branch_predict_tournament.sv
// Tournament branch predictor: local two-level + global gshare, with a chooser.
module branch_predict_tournament
    import bp_pkg::*;
#(
    parameter int unsigned PC_TAIL        = 2,
    parameter int unsigned BHT_INDEX_BITS = 3,
    parameter int unsigned BHR_BITS       = 4,
    parameter int unsigned PHT_INDEX_BITS = 7,
    parameter int unsigned GHR_BITS       = 8,
    parameter int unsigned CTR_BITS       = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pcF,
    input  logic                      branchM,
    input  logic                      actually_takenM,
    input  logic [BHT_INDEX_BITS-1:0] BHT_indexM,
    input  logic [PHT_INDEX_BITS-1:0] PHT_indexM,
    input  logic [GHR_BITS-1:0]       GPHT_indexM,
    input  logic                      local_predM,
    input  logic                      global_predM,
    output logic                      predict_takeF,
    output logic                      readyF,
    output logic [BHT_INDEX_BITS-1:0] pc_hashingF,
    output logic [PHT_INDEX_BITS-1:0] PHT_indexF,
    output logic [GHR_BITS-1:0]       GPHT_indexF,
    output logic                      local_predF,
    output logic                      global_predF
);

    localparam int unsigned SWEEP_W = max_u(PHT_INDEX_BITS, GHR_BITS);
    localparam int unsigned BHT_N   = 1 << BHT_INDEX_BITS;
    localparam int unsigned LPHT_N  = 1 << PHT_INDEX_BITS;
    localparam int unsigned GPHT_N  = 1 << GHR_BITS;
    localparam logic [CTR_BITS-1:0] PHT_INIT     = CTR_BITS'(pht_init_val(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CHOOSER_INIT = CTR_BITS'(chooser_init_val(CTR_BITS));

    bp_state_e            state_q, state_d;
    logic [SWEEP_W-1:0]   sweep_q, sweep_d;
    logic [GHR_BITS-1:0]  ghr_q, ghr_d;
    logic [BHR_BITS-1:0]  bht_q [BHT_N];
    logic [BHR_BITS-1:0]  bht_d [BHT_N];
    logic [CTR_BITS-1:0]  lpht_q [LPHT_N];
    logic [CTR_BITS-1:0]  lpht_d [LPHT_N];
    logic [CTR_BITS-1:0]  gpht_q [GPHT_N];
    logic [CTR_BITS-1:0]  gpht_d [GPHT_N];
    logic [CTR_BITS-1:0]  chooser_q [GPHT_N];
    logic [CTR_BITS-1:0]  chooser_d [GPHT_N];

    logic [CTR_BITS-1:0]  lpht_nxt, gpht_nxt, chooser_nxt;
    logic                 global_right;
    logic                 unused_pc;

    assign global_right = (global_predM == actually_takenM);
    assign unused_pc    = ^pcF;

    sat_counter_update #(.CTR_BITS(CTR_BITS)) u_lpht_ctr (
        .cnt (lpht_q[PHT_indexM]),
        .inc (actually_takenM),
        .dec (~actually_takenM),
        .nxt (lpht_nxt)
    );

    sat_counter_update #(.CTR_BITS(CTR_BITS)) u_gpht_ctr (
        .cnt (gpht_q[GPHT_indexM]),
        .inc (actually_takenM),
        .dec (~actually_takenM),
        .nxt (gpht_nxt)
    );

    sat_counter_update #(.CTR_BITS(CTR_BITS)) u_chooser_ctr (
        .cnt (chooser_q[GPHT_indexM]),
        .inc (global_right),
        .dec (~global_right),
        .nxt (chooser_nxt)
    );

    // Init sweep sequencing: one index per cycle, RUN after the last index is written.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + SWEEP_W'(1);
            if (sweep_q == '1) state_d = ST_RUN;
        end
    end

    // Table writes: sweep initialisation in INIT, branch training in RUN.
    always_comb begin
        lpht_d    = lpht_q;
        gpht_d    = gpht_q;
        chooser_d = chooser_q;
        bht_d     = bht_q;
        ghr_d     = ghr_q;
        if (state_q == ST_INIT) begin
            if (32'(sweep_q) < LPHT_N) lpht_d[sweep_q[PHT_INDEX_BITS-1:0]] = PHT_INIT;
            if (32'(sweep_q) < GPHT_N) begin
                gpht_d[sweep_q[GHR_BITS-1:0]]    = PHT_INIT;
                chooser_d[sweep_q[GHR_BITS-1:0]] = CHOOSER_INIT;
            end
        end else if (branchM) begin
            lpht_d[PHT_indexM] = lpht_nxt;
            gpht_d[GPHT_indexM] = gpht_nxt;
            if (local_predM != global_predM) chooser_d[GPHT_indexM] = chooser_nxt;
            bht_d[BHT_indexM] = {bht_q[BHT_indexM][BHR_BITS-2:0], actually_takenM};
            ghr_d = {ghr_q[GHR_BITS-2:0], actually_takenM};
        end
    end

    // Control state and history registers, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            ghr_q   <= '0;
            bht_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ghr_q   <= ghr_d;
            bht_q   <= bht_d;
        end
    end

    // Counter tables carry no reset; the INIT sweep establishes their contents.
    always_ff @(posedge clk) begin
        lpht_q    <= lpht_d;
        gpht_q    <= gpht_d;
        chooser_q <= chooser_d;
    end

    // Fetch-side lookups, purely combinational from pcF and registered state.
    always_comb begin
        readyF        = (state_q == ST_RUN);
        pc_hashingF   = pcF[BHT_INDEX_BITS-1:0];
        PHT_indexF    = {pcF[PC_TAIL+PHT_INDEX_BITS-BHR_BITS-1:PC_TAIL], bht_q[pc_hashingF]};
        GPHT_indexF   = pcF[PC_TAIL+GHR_BITS-1:PC_TAIL] ^ ghr_q;
        local_predF   = lpht_q[PHT_indexF][CTR_BITS-1];
        global_predF  = gpht_q[GPHT_indexF][CTR_BITS-1];
        predict_takeF = 1'b0;
        if (state_q == ST_RUN)
            predict_takeF = chooser_q[ghr_q][CTR_BITS-1] ? global_predF : local_predF;
    end

endmodule

// File: tb/tb_branch_predict_tournament.sv
// Self-checking bench for branch_predict_tournament against a table-level model.
module tb_branch_predict_tournament;

    localparam int unsigned PC_TAIL = 2;
    localparam int unsigned BHT_B   = 3;
    localparam int unsigned BHR_B   = 4;
    localparam int unsigned PHT_B   = 7;
    localparam int unsigned GHR_B   = 8;
    localparam int unsigned CTR_B   = 2;
    localparam int unsigned BN      = 1 << BHT_B;
    localparam int unsigned LN      = 1 << PHT_B;
    localparam int unsigned GN      = 1 << GHR_B;
    localparam int unsigned DEPTH   = (LN > GN) ? LN : GN;
    localparam int unsigned HALF    = 1 << (CTR_B - 1);
    localparam int unsigned CMAX    = (1 << CTR_B) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       pcF;
    logic              branchM, actually_takenM, local_predM, global_predM;
    logic [BHT_B-1:0]  BHT_indexM;
    logic [PHT_B-1:0]  PHT_indexM;
    logic [GHR_B-1:0]  GPHT_indexM;
    logic              predict_takeF, readyF, local_predF, global_predF;
    logic [BHT_B-1:0]  pc_hashingF;
    logic [PHT_B-1:0]  PHT_indexF;
    logic [GHR_B-1:0]  GPHT_indexF;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model state: plain integer tables.
    int unsigned m_lpht [LN];
    int unsigned m_gpht [GN];
    int unsigned m_cho  [GN];
    int unsigned m_bht  [BN];
    int unsigned m_ghr;
    int unsigned m_init_cnt;
    bit          m_ready;

    branch_predict_tournament #(
        .PC_TAIL(PC_TAIL), .BHT_INDEX_BITS(BHT_B), .BHR_BITS(BHR_B),
        .PHT_INDEX_BITS(PHT_B), .GHR_BITS(GHR_B), .CTR_BITS(CTR_B)
    ) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .branchM(branchM),
        .actually_takenM(actually_takenM), .BHT_indexM(BHT_indexM),
        .PHT_indexM(PHT_indexM), .GPHT_indexM(GPHT_indexM),
        .local_predM(local_predM), .global_predM(global_predM),
        .predict_takeF(predict_takeF), .readyF(readyF), .pc_hashingF(pc_hashingF),
        .PHT_indexF(PHT_indexF), .GPHT_indexF(GPHT_indexF),
        .local_predF(local_predF), .global_predF(global_predF)
    );

    always #5 clk = ~clk;

    function automatic int unsigned sat_step(input int unsigned v, input bit up);
        if (up) return (v >= CMAX) ? CMAX : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

    function automatic int unsigned m_bidx(input logic [31:0] pc);
        return pc % BN;
    endfunction

    function automatic int unsigned m_pidx(input logic [31:0] pc);
        return (((pc >> PC_TAIL) % (1 << (PHT_B - BHR_B))) << BHR_B) + m_bht[m_bidx(pc)];
    endfunction

    function automatic int unsigned m_gidx(input logic [31:0] pc);
        return ((pc >> PC_TAIL) % GN) ^ m_ghr;
    endfunction

    function automatic bit m_predict(input logic [31:0] pc);
        if (!m_ready) return 1'b0;
        if (m_cho[m_ghr] >= HALF) return m_gpht[m_gidx(pc)] >= HALF;
        return m_lpht[m_pidx(pc)] >= HALF;
    endfunction

    task automatic reset_model();
        foreach (m_bht[i]) m_bht[i] = 0;
        m_ghr = 0;
        m_ready = 1'b0;
        m_init_cnt = 0;
    endtask

    // Advances the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        int unsigned p, g, b;
        if (rst) return;
        if (!m_ready) begin
            m_init_cnt++;
            if (m_init_cnt == DEPTH) begin
                m_ready = 1'b1;
                foreach (m_lpht[i]) m_lpht[i] = HALF;
                foreach (m_gpht[i]) m_gpht[i] = HALF;
                foreach (m_cho[i])  m_cho[i]  = HALF - 1;
            end
        end else if (branchM) begin
            p = int'(PHT_indexM);
            g = int'(GPHT_indexM);
            b = int'(BHT_indexM);
            m_lpht[p] = sat_step(m_lpht[p], actually_takenM);
            m_gpht[g] = sat_step(m_gpht[g], actually_takenM);
            if (local_predM != global_predM)
                m_cho[g] = sat_step(m_cho[g], global_predM == actually_takenM);
            m_bht[b] = ((m_bht[b] << 1) | int'(actually_takenM)) % (1 << BHR_B);
            m_ghr    = ((m_ghr << 1) | int'(actually_takenM)) % GN;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":readyF"}, 32'(readyF), 32'(m_ready));
        chk({tag, ":predict"}, 32'(predict_takeF), 32'(m_predict(pcF)));
        chk({tag, ":pc_hash"}, 32'(pc_hashingF), m_bidx(pcF));
        chk({tag, ":pht_idx"}, 32'(PHT_indexF), m_pidx(pcF));
        chk({tag, ":gpht_idx"}, 32'(GPHT_indexF), m_gidx(pcF));
        if (m_ready) begin
            chk({tag, ":local_pred"}, 32'(local_predF), 32'(m_lpht[m_pidx(pcF)] >= HALF));
            chk({tag, ":global_pred"}, 32'(global_predF), 32'(m_gpht[m_gidx(pcF)] >= HALF));
        end
    endtask

    task automatic drive(input logic [31:0] pc, input bit br, input bit tk,
                         input int unsigned bi, input int unsigned pi, input int unsigned gi,
                         input bit lp, input bit gp);
        pcF = pc;
        branchM = br;
        actually_takenM = tk;
        BHT_indexM = BHT_B'(bi);
        PHT_indexM = PHT_B'(pi);
        GPHT_indexM = GHR_B'(gi);
        local_predM = lp;
        global_predM = gp;
    endtask

    task automatic drive_random();
        drive($urandom, 1'($urandom), 1'($urandom), $urandom % BN, $urandom % LN,
              $urandom % GN, 1'($urandom), 1'($urandom));
    endtask

    // One training update: check outputs this cycle, then clock it in.
    task automatic train(input string tag, input bit tk, input int unsigned bi,
                         input int unsigned pi, input int unsigned gi, input bit lp, input bit gp);
        drive(32'h0, 1'b1, tk, bi, pi, gi, lp, gp);
        #1;
        check_all(tag);
        tick();
    endtask

    task automatic sweep_check(input string tag);
        for (int c = 1; c <= int'(DEPTH); c++) begin
            drive_random();
            #1;
            chk({tag, ":ready_low"}, 32'(readyF), 32'(0));
            chk({tag, ":pred_low"}, 32'(predict_takeF), 32'(0));
            tick();
        end
        drive(32'h0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        chk({tag, ":ready_high"}, 32'(readyF), 32'(1));
    endtask

    initial begin
        bit bits8 [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bit bits4 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        reset_model();
        drive(32'h0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        chk("reset:readyF", 32'(readyF), 32'(0));
        chk("reset:predict", 32'(predict_takeF), 32'(0));
        tick();
        tick();
        rst = 1'b0;

        // Full sweep after power-on reset.
        sweep_check("init");

        // Fresh tables predict taken through the local side.
        for (int i = 0; i < 16; i++) begin
            drive($urandom, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
            #1;
            check_all("post_init");
            chk("post_init:local", 32'(local_predF), 32'(1));
            chk("post_init:global", 32'(global_predF), 32'(1));
            chk("post_init:predict_const", 32'(predict_takeF), 32'(1));
            tick();
        end

        // Local counter at index 5 saturates at zero.
        for (int i = 0; i < 3; i++) train("sat_down", 1'b0, 7, 5, 'h80, 1'b0, 1'b0);
        // Shape BHT[0] to 0101 so pcF=0 addresses local index 5.
        for (int i = 0; i < 4; i++) train("bht_shape", bits4[i], 0, 100, 'h81, 1'b1, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        check_all("idx5");
        chk("idx5:pht_index", 32'(PHT_indexF), 32'd5);
        chk("idx5:local_pred", 32'(local_predF), 32'(0));

        // Chooser at 0x3C trained twice toward global.
        for (int i = 0; i < 2; i++) train("cho_up", 1'b1, 7, 100, 'h3C, 1'b0, 1'b1);
        // Walk GHR to 0x3C with agreeing predictions so the chooser stays put.
        for (int i = 0; i < 8; i++) train("ghr_walk", bits8[i], 7, 100, 'h90, 1'b1, 1'b1);
        drive(32'h0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        check_all("cho_global");
        chk("cho_global:gpht_index", 32'(GPHT_indexF), 32'h3C);
        chk("cho_global:local", 32'(local_predF), 32'(0));
        chk("cho_global:global", 32'(global_predF), 32'(1));
        chk("cho_global:predict", 32'(predict_takeF), 32'(1));

        // Same-cycle update and fetch of local index 16 (pcF=4).
        drive(32'h4, 1'b1, 1'b0, 1, 16, 'h91, 1'b0, 1'b0);
        #1;
        check_all("bypass_old");
        chk("bypass_old:local", 32'(local_predF), 32'(1));
        tick();
        drive(32'h4, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        #1;
        check_all("bypass_new");
        chk("bypass_new:local", 32'(local_predF), 32'(0));

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            #1;
            check_all("random");
            tick();
        end

        // Asynchronous reset while running.
        rst = 1'b1;
        reset_model();
        #1;
        chk("rst_run:readyF", 32'(readyF), 32'(0));
        chk("rst_run:predict", 32'(predict_takeF), 32'(0));
        tick();
        rst = 1'b0;

        // Abort the sweep at index 100 and confirm it restarts from zero.
        for (int i = 0; i < 100; i++) begin
            drive_random();
            #1;
            chk("partial:ready_low", 32'(readyF), 32'(0));
            tick();
        end
        rst = 1'b1;
        reset_model();
        #1;
        chk("rst_sweep:readyF", 32'(readyF), 32'(0));
        tick();
        rst = 1'b0;
        sweep_check("resweep");

        for (int i = 0; i < 16; i++) begin
            drive($urandom, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
            #1;
            check_all("post_resweep");
            chk("post_resweep:predict_const", 32'(predict_takeF), 32'(1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predict_tournament.md
BRANCH_PREDICT_TOURNAMENT -- requirements
Module: branch_predict_tournament

Interface
REQ-001 SHALL provide parameter PC_TAIL, default 2: lowest PC bit used for indexing.
REQ-002 SHALL provide parameter BHT_INDEX_BITS, default 3: local-history table index width.
REQ-003 SHALL provide parameter BHR_BITS, default 4: per-entry local history width.
REQ-004 SHALL provide parameter PHT_INDEX_BITS, default 7: local PHT index width; PHT_INDEX_BITS > BHR_BITS.
REQ-005 SHALL provide parameter GHR_BITS, default 8: global history width, also global PHT and chooser index width.
REQ-006 SHALL provide parameter CTR_BITS, default 2: saturating counter width; CTR_BITS >= 2.
REQ-007 SHALL provide clk, input, 1: the single clock; all state changes on its rising edge.
REQ-008 SHALL provide rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL provide pcF, input, 32: fetch-stage PC.
REQ-010 SHALL provide branchM, input, 1: a resolved branch is in M; enables training.
REQ-011 SHALL provide actually_takenM, input, 1: resolved direction.
REQ-012 SHALL provide BHT_indexM, input, BHT_INDEX_BITS: pipelined pc_hashingF.
REQ-013 SHALL provide PHT_indexM, input, PHT_INDEX_BITS: pipelined PHT_indexF.
REQ-014 SHALL provide GPHT_indexM, input, GHR_BITS: pipelined GPHT_indexF.
REQ-015 SHALL provide local_predM / global_predM, input, 1 each: pipelined component predictions.
REQ-016 SHALL provide predict_takeF, output, 1: final prediction.
REQ-017 SHALL provide readyF, output, 1: table initialisation complete.
REQ-018 SHALL provide pc_hashingF, output, BHT_INDEX_BITS: pcF[BHT_INDEX_BITS-1:0].
REQ-019 SHALL provide PHT_indexF, output, PHT_INDEX_BITS: {pcF[PC_TAIL+PHT_INDEX_BITS-BHR_BITS-1:PC_TAIL], BHT[pc_hashingF]}.
REQ-020 SHALL provide GPHT_indexF, output, GHR_BITS: pcF[PC_TAIL+GHR_BITS-1:PC_TAIL] XOR GHR.
REQ-021 SHALL provide local_predF / global_predF, output, 1 each: MSB of local PHT / global PHT entry addressed.

Function
REQ-022 States SHALL be INIT and RUN; INIT sweeps index 0..D-1, D = 2^max(PHT_INDEX_BITS, GHR_BITS), one index per cycle, writing every in-range entry of local PHT, global PHT and chooser.
REQ-023 INIT SHALL go to RUN the cycle after index D-1 is written; readyF = (state == RUN).
REQ-024 In INIT, predict_takeF SHALL be 0 and branchM SHALL be ignored.
REQ-025 In RUN, predict_takeF SHALL be global_predF if chooser[GHR]'s MSB = 1, else local_predF; all F outputs combinational from pcF and current state.
REQ-026 On branchM in RUN: local PHT[PHT_indexM] and global PHT[GPHT_indexM] SHALL saturate +1 if actually_takenM, else -1, bounds 0 and 2^CTR_BITS-1.
REQ-027 On branchM in RUN with local_predM != global_predM: chooser[GPHT_indexM] SHALL saturate +1 if global_predM == actually_takenM, else -1; unchanged when they agree.
REQ-028 On branchM in RUN: BHT[BHT_indexM] <= {old[BHR_BITS-2:0], actually_takenM}; GHR <= {GHR[GHR_BITS-2:0], actually_takenM}.
REQ-029 Update and fetch read of the same entry in one cycle SHALL return the pre-update value; new value visible next cycle.
REQ-030 All arithmetic SHALL be CTR_BITS wide with explicit saturation, never wrapping.

Reset
REQ-031 rst SHALL asynchronously clear BHT entries and GHR to 0, set sweep index to 0, state to INIT, and readyF to 0.
REQ-032 Sweep SHALL write PHTs to 2^(CTR_BITS-1) (weakly taken) and chooser to 2^(CTR_BITS-1)-1 (weakly local).
REQ-033 rst asserted mid-sweep or in RUN SHALL restart INIT from index 0.

Structure
REQ-034 Package bp_pkg SHALL hold the INIT/RUN state enum and counter-init constant functions.
REQ-035 One sub-module, sat_counter_update (combinational next-value of a CTR_BITS counter given inc/dec), SHALL be instantiated for each of the three tables.

Verification
REQ-036 Defaults, rst pulse -> readyF 0 for 256 cycles, 1 on cycle 257; predict_takeF 0 throughout INIT.
REQ-037 Post-init, any pcF -> local_predF = global_predF = 1, chooser selects local, predict_takeF = 1.
REQ-038 Three not-taken updates at PHT_indexM=5 -> counter 2->1->0->0 (saturates); local_predF at index 5 = 0.
REQ-039 Updates with local_predM=0, global_predM=1, actually_takenM=1 twice at GPHT_indexM=0x3C -> chooser 1->2->3; GHR=0x3C lookup selects global.
REQ-040 Update and fetch same index same cycle -> fetch sees old MSB, next cycle sees new; rst at sweep index 100 -> sweep restarts at 0, readyF 256 cycles after release.
